gol_row_streamer: RTL and testbench
===================================

Name: gol_row_streamer

Overview:
- Reader side of the Game of Life flattened grid: snapshots the row-major N-row by M-column `state` vector once per generation.
- Streams the snapshot out one row per handshake, rows 0 to N-1, over a valid/ready interface.
- Sits between the Game of Life core and a display or UART/VGA row consumer.
- Downstream back-pressure never stalls the core: generations that arrive while a frame is still streaming are dropped and counted.

Parameters:
- M, 16, grid columns (cells per row); M >= 2.
- N, 16, grid rows; N >= 2.
- DROP_W, 8, width of the saturating dropped-generation counter.

Ports:
- clk_i  input  1  single clock, rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- state_i  input  N*M  row-major grid from the core; cell (x,y) is bit y*M+x.
- gen_tick_i  input  1  one-cycle pulse: state_i holds a new generation this cycle.
- row_ready_i  input  1  consumer accepts the current row.
- row_valid_o  output  1  row_data_o, row_idx_o and row_live_o are valid.
- row_data_o  output  M  current row; bit x = cell (x, row_idx_o).
- row_idx_o  output  max(1,$clog2(N))  index of the current row.
- row_live_o  output  $clog2(M+1)  live-cell count of the current row.
- frame_first_o  output  1  high with row 0 (row_valid_o & row_idx_o==0).
- frame_last_o  output  1  high with row N-1.
- busy_o  output  1  a frame is being streamed.
- drop_count_o  output  DROP_W  number of dropped generations, saturating.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - FSM goes to IDLE; snapshot and row index are cleared.
  - row_valid_o, busy_o, frame_first_o and frame_last_o are 0; drop_count_o is 0.
  - row_data_o, row_idx_o and row_live_o are 0.
- FSM has two states, IDLE and STREAM.
- IDLE:
  - On gen_tick_i, capture state_i into the snapshot register, set row index to 0 and go to STREAM.
  - Latency: tick at cycle t gives row_valid_o=1 with row 0 at cycle t+1.
- STREAM:
  - row_valid_o=1 and busy_o=1.
  - row_data_o = snapshot[row*M +: M]; row_live_o is the popcount of that slice.
  - All outputs are held stable while row_valid_o=1 and row_ready_i=0.
  - A transfer occurs on a cycle with row_valid_o & row_ready_i.
  - On transfer with row < N-1, the row index increments next cycle.
  - On transfer with row == N-1 and no gen_tick_i, go to IDLE; row_valid_o=0 next cycle.
  - Back-to-back: if row_ready_i stays high, one row transfers per cycle; a full frame takes N cycles.
- Tick during STREAM: not captured; drop_count_o increments by 1 and saturates at 2^DROP_W-1.
  - Exception: a tick coinciding with the final-row transfer is accepted, not dropped.
  - In that case the new snapshot is captured, the FSM stays in STREAM and row 0 of the new frame is valid next cycle, with no idle bubble.
- The snapshot changes only on an accepted tick. state_i changing mid-frame has no effect on the streamed frame.
- row_valid_o never drops without a transfer, except on reset.
- Reset mid-frame aborts the frame immediately. No partial-frame resume.
- Row index arithmetic is unsigned, compared against N-1; it never exceeds N-1.
- drop_count_o is cleared only by reset.
- Outputs are registered, or derived combinationally from registered state only. There is no combinational path from row_ready_i to any output.

Decomposition:
- Package gol_pkg:
  - stream_state_t enum (IDLE, STREAM).
  - Helper function for row-index width, giving max(1,$clog2(N)).
  - Default M/N constants shared with the Game of Life core.
- Sub-module gol_row_popcount, parameter M: combinational M-bit row to $clog2(M+1)-bit live count. Reused later for whole-grid population statistics.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset_n_i=0, release, no ticks for 20 cycles.
  - Response: all outputs 0, busy_o=0, drop_count_o=0.
- Single frame, always ready (M=N=16):
  - Stimulus: glider seed with row 1 = 0x0004, row 2 = 0x0001, row 3 = 0x0007; pulse gen_tick_i; row_ready_i=1.
  - Response: rows 0..15 appear on consecutive cycles starting at tick+1.
  - Row 1 data 0x0004, live 1; row 3 data 0x0007, live 3; frame_first_o on row 0; frame_last_o on row 15; then IDLE.
- Back-pressure:
  - Stimulus: row_ready_i toggles 1,0,0,1 repeating.
  - Response: data, idx and live are held constant during stalls; 16 transfers total with no row skipped or duplicated.
- Overrun:
  - Stimulus: row_ready_i=0 and 3 ticks during STREAM.
  - Response: drop_count_o=3; streamed frame equals the first snapshot even though state_i changed.
  - Saturation: 300 drops with DROP_W=8 gives drop_count_o=255.
- Seamless restart:
  - Stimulus: tick on the same cycle as the row-15 transfer.
  - Response: next cycle row_valid_o=1, row_idx_o=0 with the new grid data; drop_count_o unchanged.
- Reset mid-frame:
  - Stimulus: assert reset_n_i at row 7 with row_ready_i=0.
  - Response: row_valid_o=0 immediately (async).
  - After release, the next tick streams from row 0.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared Game of Life types and constants: grid defaults, row-streamer FSM
// states and the row-index width helper.
package gol_pkg;

  localparam int GOL_M = 16;
  localparam int GOL_N = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

  // Row-index width: max(1, $clog2(n)), so a two-row grid still gets one bit.
  function automatic int row_idx_w(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gol_row_popcount.sv
// Combinational live-cell count of one M-cell row; also meant for whole-grid
// population statistics.
module gol_row_popcount #(
  parameter int M = 16
) (
  input  logic [M-1:0]            row_i,
  output logic [$clog2(M+1)-1:0]  live_o
);

  localparam int CW = $clog2(M + 1);

  // Sum of set cells in the row.
  always_comb begin
    live_o = '0;
    for (int i = 0; i < M; i++) begin
      live_o = live_o + {{(CW - 1){1'b0}}, row_i[i]};
    end
  end

endmodule

// File: rtl/gol_row_streamer.sv
// Snapshots the Game of Life grid on each accepted generation tick and
// streams it row by row over valid/ready, dropping generations that overrun.
module gol_row_streamer
  import gol_pkg::*;
#(
  parameter int M      = GOL_M,
  parameter int N      = GOL_N,
  parameter int DROP_W = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [N*M-1:0]                state_i,
  input  logic                          gen_tick_i,
  input  logic                          row_ready_i,
  output logic                          row_valid_o,
  output logic [M-1:0]                  row_data_o,
  output logic [row_idx_w(N)-1:0]       row_idx_o,
  output logic [$clog2(M+1)-1:0]        row_live_o,
  output logic                          frame_first_o,
  output logic                          frame_last_o,
  output logic                          busy_o,
  output logic [DROP_W-1:0]             drop_count_o
);

  localparam int IW = row_idx_w(N);
  localparam int CW = $clog2(M + 1);
  localparam logic [IW-1:0] LAST_ROW = IW'(N - 1);

  stream_state_t        state_q, state_d;
  logic [N*M-1:0]       snap_q, snap_d;
  logic [IW-1:0]        row_q, row_d;
  logic [DROP_W-1:0]    drop_q, drop_d;

  logic                 streaming_s;
  logic                 xfer_s;
  logic                 last_s;
  logic [M-1:0]         rows_s [N];
  logic [M-1:0]         cur_row_s;
  logic [CW-1:0]        cur_live_s;

  assign streaming_s = (state_q == STREAM);
  assign xfer_s      = streaming_s & row_ready_i;
  assign last_s      = (row_q == LAST_ROW);

  // Select the current row out of the snapshot.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      rows_s[r] = snap_q[r*M +: M];
    end
    cur_row_s = rows_s[row_q];
  end

  gol_row_popcount #(.M(M)) u_popcount (
    .row_i  (cur_row_s),
    .live_o (cur_live_s)
  );

  // Next-state logic: frame capture, row advance, seamless restart, drops.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    row_d   = row_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (gen_tick_i) begin
          snap_d  = state_i;
          row_d   = '0;
          state_d = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (xfer_s && !last_s) begin
          row_d = row_q + {{(IW - 1){1'b0}}, 1'b1};
        end else if (xfer_s && gen_tick_i) begin
          // Tick on the final-row transfer starts the next frame with no bubble.
          snap_d  = state_i;
          row_d   = '0;
          state_d = STREAM;
        end else if (xfer_s) begin
          row_d   = '0;
          state_d = IDLE;
        end else begin
          row_d = row_q;
        end
        if (gen_tick_i && !(xfer_s && last_s) && (drop_q != {DROP_W{1'b1}})) begin
          drop_d = drop_q + {{(DROP_W - 1){1'b0}}, 1'b1};
        end else begin
          drop_d = drop_q;
        end
      end
      default: begin
        state_d = IDLE;
        row_d   = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      snap_q  <= '0;
      row_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      row_q   <= row_d;
      drop_q  <= drop_d;
    end
  end

  // Outputs depend on registered state only; row fields read zero when idle.
  always_comb begin
    row_valid_o  = streaming_s;
    busy_o       = streaming_s;
    drop_count_o = drop_q;
    if (streaming_s) begin
      row_data_o    = cur_row_s;
      row_idx_o     = row_q;
      row_live_o    = cur_live_s;
      frame_first_o = (row_q == '0);
      frame_last_o  = last_s;
    end else begin
      row_data_o    = '0;
      row_idx_o     = '0;
      row_live_o    = '0;
      frame_first_o = 1'b0;
      frame_last_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_gol_row_streamer.sv
// Randomized self-checking bench for gol_row_streamer against a frame-queue
// reference model (M=N=16, DROP_W=8).
module tb_gol_row_streamer;

  localparam int M = 16;
  localparam int N = 16;
  localparam int DW = 8;

  logic            clk_i = 1'b0;
  logic            reset_n_i = 1'b0;
  logic [N*M-1:0]  state_i = '0;
  logic            gen_tick_i = 1'b0;
  logic            row_ready_i = 1'b0;
  logic            row_valid_o;
  logic [M-1:0]    row_data_o;
  logic [3:0]      row_idx_o;
  logic [4:0]      row_live_o;
  logic            frame_first_o;
  logic            frame_last_o;
  logic            busy_o;
  logic [DW-1:0]   drop_count_o;

  gol_row_streamer #(.M(M), .N(N), .DROP_W(DW)) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .state_i       (state_i),
    .gen_tick_i    (gen_tick_i),
    .row_ready_i   (row_ready_i),
    .row_valid_o   (row_valid_o),
    .row_data_o    (row_data_o),
    .row_idx_o     (row_idx_o),
    .row_live_o    (row_live_o),
    .frame_first_o (frame_first_o),
    .frame_last_o  (frame_last_o),
    .busy_o        (busy_o),
    .drop_count_o  (drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: rows still owed to the consumer, and the drop tally.
  logic [M-1:0] exp_q[$];
  int           exp_drop = 0;
  int           xfer_count = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*M-1:0] rand_grid();
    logic [N*M-1:0] g;
    for (int i = 0; i < N*M; i += 32) g[i +: 32] = $urandom;
    return g;
  endfunction

  task automatic check_outputs();
    check("valid", row_valid_o, exp_q.size() > 0);
    check("busy", busy_o, exp_q.size() > 0);
    check("drop", drop_count_o, exp_drop);
    if (exp_q.size() > 0) begin
      check("data", row_data_o, exp_q[0]);
      check("idx", row_idx_o, N - exp_q.size());
      check("live", row_live_o, $countones(exp_q[0]));
      check("first", frame_first_o, exp_q.size() == N);
      check("last", frame_last_o, exp_q.size() == 1);
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, check after it.
  task automatic step(input logic tick, input logic ready, input logic [N*M-1:0] grid);
    bit xfer, accept;
    gen_tick_i  = tick;
    row_ready_i = ready;
    state_i     = grid;
    @(posedge clk_i);
    xfer   = (exp_q.size() > 0) && ready;
    accept = tick && ((exp_q.size() == 0) || (xfer && exp_q.size() == 1));
    if (xfer) begin
      void'(exp_q.pop_front());
      xfer_count++;
    end
    if (tick && !accept && exp_drop < 255) exp_drop++;
    if (accept) for (int r = 0; r < N; r++) exp_q.push_back(grid[r*M +: M]);
    #1;
    check_outputs();
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      step(1'b0, 1'b1, rand_grid());
      guard++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    logic [N*M-1:0] g, g2;

    // Reset then idle
    #12;
    check("rst_valid", row_valid_o, 1'b0);
    check("rst_data", row_data_o, 16'h0000);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, $urandom_range(0, 1), rand_grid());
    check("idle_idx", row_idx_o, 4'd0);
    check("idle_live", row_live_o, 5'd0);

    // Glider frame, consumer always ready
    g = '0;
    g[1*M +: M] = 16'h0004;
    g[2*M +: M] = 16'h0001;
    g[3*M +: M] = 16'h0007;
    step(1'b1, 1'b1, g);
    for (int i = 0; i < N; i++) begin
      check("glider_idx", row_idx_o, i);
      if (i == 1) begin
        check("glider_r1", row_data_o, 16'h0004);
        check("glider_r1_live", row_live_o, 5'd1);
      end
      if (i == 3) begin
        check("glider_r3", row_data_o, 16'h0007);
        check("glider_r3_live", row_live_o, 5'd3);
      end
      step(1'b0, 1'b1, rand_grid());
    end
    check("glider_idle", row_valid_o, 1'b0);

    // Back-pressure 1,0,0,1
    step(1'b1, 1'b0, rand_grid());
    xfer_count = 0;
    for (int i = 0; i < 80 && exp_q.size() > 0; i++)
      step(1'b0, (i % 4 == 0) || (i % 4 == 3), rand_grid());
    check("bp_xfers", xfer_count, 16);
    check("bp_idle", row_valid_o, 1'b0);

    // Overrun: three ticks while stalled, frame keeps first snapshot
    g = rand_grid();
    step(1'b1, 1'b0, g);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rand_grid());
    check("overrun_drop3", drop_count_o, 8'd3);
    check("overrun_row0", row_data_o, g[0 +: M]);
    drain();

    // Saturation
    step(1'b1, 1'b0, rand_grid());
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, rand_grid());
    check("drop_sat", drop_count_o, 8'd255);
    drain();

    // Seamless restart on the final-row transfer
    step(1'b1, 1'b1, rand_grid());
    while (exp_q.size() > 1) step(1'b0, 1'b1, rand_grid());
    g2 = rand_grid();
    step(1'b1, 1'b1, g2);
    check("seam_valid", row_valid_o, 1'b1);
    check("seam_idx", row_idx_o, 4'd0);
    check("seam_data", row_data_o, g2[0 +: M]);
    check("seam_drop", drop_count_o, 8'd255);
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, rand_grid());
    drain();

    // Reset mid-frame at row 7
    step(1'b1, 1'b1, rand_grid());
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, rand_grid());
    step(1'b0, 1'b0, rand_grid());
    check("pre_rst_idx", row_idx_o, 4'd7);
    #2 reset_n_i = 1'b0;
    #1;
    exp_q.delete();
    exp_drop = 0;
    check("rst_mid_valid", row_valid_o, 1'b0);
    check("rst_mid_drop", drop_count_o, 8'd0);
    check("rst_mid_busy", busy_o, 1'b0);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    g = rand_grid();
    step(1'b1, 1'b0, g);
    check("post_rst_idx", row_idx_o, 4'd0);
    check("post_rst_row0", row_data_o, g[0 +: M]);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
